addsub_fixed_pipe: RTL and testbench
====================================

ADDSUB_FIXED_PIPE -- requirements
Module: addsub_fixed_pipe

Interface
REQ-001 SHALL have parameter N, default 20, total word width in sign-magnitude format (bit N-1 = sign, bits N-2:0 = magnitude).
REQ-002 SHALL have parameter Q, default 11, fractional bits; legal range 1 <= Q <= N-2.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  input transaction present.
REQ-006 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-007 SHALL have port in_op  input  1  0 = a+b, 1 = a-b.
REQ-008 SHALL have port in_a  input  N  operand a, sign-magnitude Q-format.
REQ-009 SHALL have port in_b  input  N  operand b, sign-magnitude Q-format.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_c  output  N  result, sign-magnitude Q-format.
REQ-013 SHALL have port out_sat  output  1  result was clamped.
REQ-014 SHALL have port sat_clr  input  1  synchronous clear of sat_count.
REQ-015 SHALL have port sat_count  output  16  count of saturated results delivered.

Function
REQ-016 SHALL accept an input when in_valid and in_ready are both high; SHALL deliver when out_valid and out_ready are both high.
REQ-017 SHALL be a 2-stage pipeline: S1 registers effective b sign (b sign XOR in_op), magnitude compare, raw N-bit magnitude (incl. carry) and result sign; S2 registers saturated/normalised result.
REQ-018 Latency SHALL be 2 cycles from accept to out_valid with no stall; throughput 1 result/cycle.
REQ-019 Stage advance SHALL be: S2 loads when S2 empty or out_ready high; S1 loads when S1 empty or S1 advances; in_ready = S1 empty or S1 advances (combinational, no dependence on in_valid).
REQ-020 Results SHALL leave in acceptance order; no loss or duplication under any out_ready pattern; out_c/out_sat SHALL hold stable while out_valid high and out_ready low.
REQ-021 Same effective signs: magnitude = |a|+|b|, sign = a sign.
REQ-022 Differing effective signs: magnitude = larger minus smaller; sign = sign of larger-magnitude operand; equal magnitudes give +0.
REQ-023 SAT_MAG SHALL equal (2^(N-1-Q) - 1) * 2^Q; if raw magnitude >= SAT_MAG, out magnitude = SAT_MAG, sign kept, out_sat = 1; else out_sat = 0.
REQ-024 A zero magnitude result SHALL always carry sign 0 (no negative zero), including -0 operands.
REQ-025 sat_count SHALL increment by 1 on each delivered result with out_sat = 1, saturating at 0xFFFF; sat_clr SHALL zero it next edge, with sat_clr taking priority over a same-cycle increment.

Reset
REQ-026 On rst_n low, asynchronously: S1/S2 valid = 0, out_valid = 0, out_c = 0, out_sat = 0, sat_count = 0; in_ready SHALL read 1 during and after reset.
REQ-027 Reset mid-operation SHALL discard all in-flight results; no result from pre-reset inputs SHALL appear after release.

Configuration
REQ-028 With macro ADDSUB_SAT_CNT_EN defined, sat_count and sat_clr SHALL behave per REQ-025.
REQ-029 Without ADDSUB_SAT_CNT_EN, sat_count SHALL be constant 0, sat_clr ignored, no counter register synthesised; all other behaviour unchanged.

Verification (N=20, Q=11)
REQ-030 add 0x00C00 (+1.5) + 0x01200 (+2.25), out_ready=1 -> out_c 0x01E00, out_sat 0, out_valid exactly 2 cycles after accept.
REQ-031 in_op=1, a 0x00800 (+1.0), b 0x01800 (+3.0) -> out_c 0x81000 (-2.0), out_sat 0.
REQ-032 add 0x64000 (+200) + 0x32000 (+100) -> out_c 0x7F800, out_sat 1, sat_count 1 (macro defined) / 0 (undefined); then sat_clr -> sat_count 0.
REQ-033 add 0x80800 (-1.0) + 0x00800 (+1.0), and 0x80000 + 0x00000 -> out_c 0x00000 both.
REQ-034 out_ready low 4 cycles, in_valid high with 4 distinct inputs -> exactly 2 accepted then in_ready low; on out_ready high all results emerge in order, none lost.
REQ-035 rst_n low with 2 results in flight -> out_valid 0 immediately, sat_count 0; after release no stale result appears, next input gives result after 2 cycles.

Source files
------------

// File: rtl/addsub_fixed_pipe.sv
// Two-stage sign-magnitude Q-format adder/subtractor with saturation and valid/ready flow control.
// Define ADDSUB_SAT_CNT_EN to build the delivered-saturation counter (sat_count / sat_clr).
module addsub_fixed_pipe #(
  parameter int N = 20,
  parameter int Q = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_c,
  output logic         out_sat,
  input  logic         sat_clr,
  output logic [15:0]  sat_count
);

  localparam int M = N - 1;
  // (2^(N-1-Q) - 1) * 2^Q == 2^(N-1) - 2^Q
  localparam logic [N-1:0] SAT_MAG = N'((64'd1 << (N - 1)) - (64'd1 << Q));

  logic         a_sign;
  logic         b_sign_eff;
  logic         a_ge_b;
  logic [M-1:0] a_mag;
  logic [M-1:0] b_mag;
  logic [N-1:0] raw_d;
  logic         sign_d;

  logic         s1_valid;
  logic         s1_b_sign_eff;
  logic         s1_a_ge_b;
  logic [N-1:0] s1_raw;
  logic         s1_sign;

  logic         s2_load;
  logic         sat_d;
  logic [M-1:0] mag_d;
  logic [N-1:0] c_d;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_comb begin
    a_sign     = in_a[N-1];
    b_sign_eff = in_b[N-1] ^ in_op;
    a_mag      = in_a[M-1:0];
    b_mag      = in_b[M-1:0];
    a_ge_b     = (a_mag >= b_mag);
    raw_d      = '0;
    sign_d     = 1'b0;
    if (a_sign == b_sign_eff) begin
      raw_d  = {1'b0, a_mag} + {1'b0, b_mag};
      sign_d = a_sign;
    end else if (a_ge_b) begin
      raw_d  = {1'b0, a_mag - b_mag};
      sign_d = a_sign;
    end else begin
      raw_d  = {1'b0, b_mag - a_mag};
      sign_d = b_sign_eff;
    end
    // Zero magnitude (equal operands or -0 inputs) always yields +0
    if (raw_d == '0)
      sign_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid      <= 1'b0;
      s1_b_sign_eff <= 1'b0;
      s1_a_ge_b     <= 1'b0;
      s1_raw        <= '0;
      s1_sign       <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_b_sign_eff <= b_sign_eff;
        s1_a_ge_b     <= a_ge_b;
        s1_raw        <= raw_d;
        s1_sign       <= sign_d;
      end
    end
  end

  always_comb begin
    sat_d = (s1_raw >= SAT_MAG);
    mag_d = sat_d ? SAT_MAG[M-1:0] : s1_raw[M-1:0];
    c_d   = {s1_sign && (mag_d != '0), mag_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_c     <= '0;
      out_sat   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_c   <= c_d;
        out_sat <= sat_d;
      end
    end
  end

  // Operand-sign/compare flags are kept in S1 for debug visibility only
  logic unused_s1_flags;
  assign unused_s1_flags = s1_b_sign_eff ^ s1_a_ge_b;

`ifdef ADDSUB_SAT_CNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_cnt_q <= '0;
    else if (sat_clr)
      sat_cnt_q <= '0;
    else if (out_valid && out_ready && out_sat && (sat_cnt_q != '1))
      sat_cnt_q <= sat_cnt_q + 16'd1;
  end

  assign sat_count = sat_cnt_q;
`else
  logic unused_sat_clr;
  assign unused_sat_clr = sat_clr;
  assign sat_count      = '0;
`endif

endmodule

// File: tb/tb_addsub_fixed_pipe.sv
// Scoreboard bench for addsub_fixed_pipe (N=20, Q=11) with directed, hand-computed vectors.
module tb_addsub_fixed_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [19:0] in_a;
  logic [19:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_c;
  logic        out_sat;
  logic        sat_clr;
  logic [15:0] sat_count;

  addsub_fixed_pipe #(.N(20), .Q(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_sat(out_sat),
    .sat_clr(sat_clr), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] c;
    logic        sat;
    bit          lat;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned exp_sat_cnt = 0;
  bit          held = 1'b0;
  logic [19:0] held_c;
  logic        held_sat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] sat_cnt_model();
`ifdef ADDSUB_SAT_CNT_EN
    return 16'(exp_sat_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  // Monitor: pops expected result on each handshake, checks hold stability while stalled
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held && out_valid) begin
        check("hold_c", {12'd0, out_c}, {12'd0, held_c});
        check("hold_sat", {31'd0, out_sat}, {31'd0, held_sat});
      end
      held = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_c", {12'd0, out_c}, {12'd0, e.c});
          check("out_sat", {31'd0, out_sat}, {31'd0, e.sat});
          if (e.lat) check("latency", cyc - e.cyc, 32'd2);
          if (e.sat) exp_sat_cnt++;
        end
      end else if (out_valid) begin
        held     = 1'b1;
        held_c   = out_c;
        held_sat = out_sat;
      end
    end
  end

  // Called at a negedge; returns at the following negedge after acceptance
  task automatic send(input bit op, input logic [19:0] a, input logic [19:0] b,
                      input logic [19:0] c, input bit sat, input bit lat);
    int unsigned n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd1, 32'd0);
    end else begin
      exp_t e;
      e.c = c; e.sat = sat; e.lat = lat; e.cyc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", sb.size(), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  logic [19:0] st_a [4] = '{20'h00800, 20'h01000, 20'h01800, 20'h02000};
  logic [19:0] st_c [4] = '{20'h01000, 20'h01800, 20'h02000, 20'h02800};

  initial begin
    int unsigned acc;
    int unsigned idx;
    rst_n = 1'b0; in_valid = 1'b0; in_op = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1; sat_clr = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_c", {12'd0, out_c}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
    check("rst_sat_count", {16'd0, sat_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(1'b0, 20'h00C00, 20'h01200, 20'h01E00, 1'b0, 1'b1);  // 1.5 + 2.25
    send(1'b1, 20'h00800, 20'h01800, 20'h81000, 1'b0, 1'b0);  // 1.0 - 3.0
    send(1'b0, 20'h64000, 20'h32000, 20'h7F800, 1'b1, 1'b0);  // 200 + 100 clamps
    drain();
    check("sat_count_after_sat", {16'd0, sat_count}, {16'd0, sat_cnt_model()});
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    exp_sat_cnt = 0;
    #1;
    check("sat_count_cleared", {16'd0, sat_count}, 32'd0);

    send(1'b0, 20'h80800, 20'h00800, 20'h00000, 1'b0, 1'b0);  // -1 + 1
    send(1'b0, 20'h80000, 20'h00000, 20'h00000, 1'b0, 1'b0);  // -0 + 0
    send(1'b0, 20'h80000, 20'h80000, 20'h00000, 1'b0, 1'b0);  // -0 + -0
    send(1'b1, 20'hE4000, 20'h32000, 20'hFF800, 1'b1, 1'b0);  // -200 - 100 clamps negative
    send(1'b0, 20'h7F000, 20'h00400, 20'h7F400, 1'b0, 1'b0);  // just below SAT_MAG
    send(1'b0, 20'h7F000, 20'h00800, 20'h7F800, 1'b1, 1'b0);  // exactly SAT_MAG
    send(1'b0, 20'h00400, 20'h80C00, 20'h80800, 1'b0, 1'b0);  // 0.5 + -1.5
    send(1'b1, 20'h80800, 20'h80400, 20'h80400, 1'b0, 1'b0);  // -1 - (-0.5)
    drain();
    check("sat_count_two", {16'd0, sat_count}, {16'd0, sat_cnt_model()});

    // Stall: out_ready low for 4 cycles with in_valid held high
    out_ready = 1'b0;
    acc = 0;
    idx = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_op = 1'b0; in_a = st_a[idx]; in_b = 20'h00800;
      #1;
      if (in_ready) begin
        exp_t e;
        e.c = st_c[idx]; e.sat = 1'b0; e.lat = 1'b0; e.cyc = cyc;
        sb.push_back(e);
        acc++;
        idx++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check("stall_accepted", acc, 32'd2);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    while (idx < 4) begin
      send(1'b0, st_a[idx], 20'h00800, st_c[idx], 1'b0, 1'b0);
      idx++;
    end
    drain();

    // Reset with two results in flight
    out_ready = 1'b0;
    send(1'b0, 20'h64000, 20'h64000, 20'h7F800, 1'b1, 1'b0);
    send(1'b0, 20'h00800, 20'h00800, 20'h01000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    exp_sat_cnt = 0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sat_count", {16'd0, sat_count}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    send(1'b0, 20'h00C00, 20'h00400, 20'h01000, 1'b0, 1'b1);   // 1.5 + 0.5
    drain();
    check("final_sat_count", {16'd0, sat_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
